// File: rtl/cmp_rgb_filter.sv
// Clocked magnitude comparator driving a one-hot red/green/blue indicator.
// A persistence filter commits a new colour only after HOLD consecutive enabled cycles.
module cmp_rgb_filter #(
    parameter int WIDTH  = 8,
    parameter int HOLD   = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             red,
    output logic             green,
    output logic             blue,
    output logic             changed
);

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_GT   = 2'b01,
        CLS_EQ   = 2'b10,
        CLS_LT   = 2'b11
    } cls_t;

    typedef enum logic {
        STABLE,
        PENDING
    } state_t;

    localparam int             CW     = $clog2(HOLD + 1);
    localparam logic [CW-1:0]  HOLD_C = CW'(HOLD);

    logic    a_gt_b;
    logic    a_lt_b;
    cls_t    cls_d;
    cls_t    cls_q;

    cls_t    disp_q, disp_d;
    cls_t    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] n;
    state_t  state_q, state_d;
    logic    changed_q, changed_d;

    if (SIGNED) begin : g_signed_cmp
        assign a_gt_b = $signed(a) > $signed(b);
        assign a_lt_b = $signed(a) < $signed(b);
    end else begin : g_unsigned_cmp
        assign a_gt_b = a > b;
        assign a_lt_b = a < b;
    end

    assign cls_d = a_gt_b ? CLS_GT : (a_lt_b ? CLS_LT : CLS_EQ);

    // Filter next-state: a candidate must arrive on HOLD consecutive enabled edges.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        disp_d    = disp_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        changed_d = 1'b0;
        n         = '0;
        if (en) begin
            if (cls_q == disp_q) begin
                state_d = STABLE;
                cnt_d   = '0;
            end else begin
                n      = (state_q == PENDING && cls_q == cand_q) ? cnt_q + CW'(1) : CW'(1);
                cand_d = cls_q;
                if (n == HOLD_C) begin
                    disp_d    = cls_q;
                    changed_d = 1'b1;
                    state_d   = STABLE;
                    cnt_d     = '0;
                end else begin
                    state_d = PENDING;
                    cnt_d   = n;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            cls_q     <= CLS_NONE;
            disp_q    <= CLS_NONE;
            cand_q    <= CLS_NONE;
            cnt_q     <= '0;
            state_q   <= STABLE;
            changed_q <= 1'b0;
        end else begin
            if (en) begin
                cls_q <= cls_d;
            end
            disp_q    <= disp_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            changed_q <= changed_d;
        end
    end

    assign red     = (disp_q == CLS_GT);
    assign green   = (disp_q == CLS_EQ);
    assign blue    = (disp_q == CLS_LT);
    assign changed = changed_q;

endmodule

// File: tb/tb_cmp_rgb_filter.sv
// Self-checking bench for cmp_rgb_filter: four parameterisations driven by directed
// scenarios and random stimulus, checked against a run-length reference model.
module tb_cmp_rgb_filter;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic [7:0] a0, b0;
    logic [7:0] a_s, b_s;
    logic [1:0] aw, bw;
    logic [N-1:0] red, green, blue, changed;

    int checks   = 0;
    int failures = 0;

    // Instance 0: 8-bit, HOLD=4, unsigned. 1/2: 8-bit, HOLD=1, signed/unsigned on shared operands.
    // Instance 3: 2-bit, HOLD=1, unsigned.
    cmp_rgb_filter #(.WIDTH(8), .HOLD(4), .SIGNED(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .a(a0), .b(b0),
        .red(red[0]), .green(green[0]), .blue(blue[0]), .changed(changed[0]));
    cmp_rgb_filter #(.WIDTH(8), .HOLD(1), .SIGNED(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .a(a_s), .b(b_s),
        .red(red[1]), .green(green[1]), .blue(blue[1]), .changed(changed[1]));
    cmp_rgb_filter #(.WIDTH(8), .HOLD(1), .SIGNED(1'b0)) dut2 (
        .clk(clk), .rst(rst), .en(en), .a(a_s), .b(b_s),
        .red(red[2]), .green(green[2]), .blue(blue[2]), .changed(changed[2]));
    cmp_rgb_filter #(.WIDTH(2), .HOLD(1), .SIGNED(1'b0)) dut3 (
        .clk(clk), .rst(rst), .en(en), .a(aw), .b(bw),
        .red(red[3]), .green(green[3]), .blue(blue[3]), .changed(changed[3]));

    // Reference model: classes 0=none 1=gt 2=eq 3=lt. The filter input stream is the
    // class captured one enabled edge earlier; a run of HOLD identical values that
    // differs from the displayed class commits it.
    int m_cls  [N];
    int m_last [N];
    int m_run  [N];
    int m_disp [N];
    bit m_chg  [N];

    function automatic int hold_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int cls_of(int av, int bv);
        if (av > bv) return 1;
        if (av == bv) return 2;
        return 3;
    endfunction

    function automatic logic [3:0] exp_out(int i);
        return {m_disp[i] == 1, m_disp[i] == 2, m_disp[i] == 3, m_chg[i]};
    endfunction

    function automatic logic [3:0] onehot(int c);
        return {c == 1, c == 2, c == 3, 1'b0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cls[i]  = 0;
            m_last[i] = 0;
            m_run[i]  = 0;
            m_disp[i] = 0;
            m_chg[i]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        int av, bv, in_cls;
        if (rst) return;
        for (int i = 0; i < N; i++) begin
            m_chg[i] = 1'b0;
            if (!en) continue;
            case (i)
                0:       begin av = int'(a0);           bv = int'(b0);           end
                1:       begin av = int'($signed(a_s)); bv = int'($signed(b_s)); end
                2:       begin av = int'(a_s);          bv = int'(b_s);          end
                default: begin av = int'(aw);           bv = int'(bw);           end
            endcase
            in_cls   = m_cls[i];
            m_cls[i] = cls_of(av, bv);
            if (in_cls == m_last[i]) begin
                m_run[i]++;
            end else begin
                m_last[i] = in_cls;
                m_run[i]  = 1;
            end
            if (in_cls != m_disp[i] && m_run[i] == hold_of(i)) begin
                m_disp[i] = in_cls;
                m_chg[i]  = 1'b1;
            end
        end
    endtask

    // One clock edge; model follows the edge, outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        a0 = '0; b0 = '0; a_s = '0; b_s = '0; aw = '0; bw = '0;
        model_reset();
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({red[i], green[i], blue[i], changed[i]} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_async inst%0d: rgbc=%b expected 0000", i,
                         {red[i], green[i], blue[i], changed[i]});
            end
        end
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            for (int i = 0; i < N; i++) begin
                checks++;
                if ({red[i], green[i], blue[i], changed[i]} !== 4'b0000) begin
                    failures++;
                    $display("FAIL reset_en_low inst%0d cyc%0d: rgbc=%b expected 0000", i, k,
                             {red[i], green[i], blue[i], changed[i]});
                end
            end
        end
    endtask

    task automatic test_commit_latency();
        logic [3:0] want;
        a0 = 8'd5; b0 = 8'd3; en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            want = {k >= 5, 1'b0, 1'b0, k == 5};
            checks++;
            if ({red[0], green[0], blue[0], changed[0]} !== want) begin
                failures++;
                $display("FAIL commit_latency edge%0d: rgbc=%b expected %b", k,
                         {red[0], green[0], blue[0], changed[0]}, want);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] want;
        a0 = 8'd7; b0 = 8'd7;
        step(); step(); step();
        a0 = 8'd9;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            else step();
            checks++;
            if ({red[0], green[0], blue[0], changed[0]} !== 4'b1000) begin
                failures++;
                $display("FAIL glitch_reject cyc%0d: rgbc=%b expected 1000", k,
                         {red[0], green[0], blue[0], changed[0]});
            end
        end
        a0 = 8'd7;
        for (int k = 1; k <= 6; k++) begin
            step();
            want = (k < 5) ? 4'b1000 : {3'b010, k == 5};
            checks++;
            if ({red[0], green[0], blue[0], changed[0]} !== want) begin
                failures++;
                $display("FAIL glitch_then_eq edge%0d: rgbc=%b expected %b", k,
                         {red[0], green[0], blue[0], changed[0]}, want);
            end
        end
    endtask

    task automatic test_signed();
        a_s = 8'hFF; b_s = 8'h01; en = 1'b1;
        step();
        checks++;
        if ({red[2:1], green[2:1], blue[2:1], changed[2:1]} !== 8'b00_11_00_00) begin
            failures++;
            $display("FAIL signed_edge1: r=%b g=%b b=%b c=%b expected r=00 g=11 b=00 c=00",
                     red[2:1], green[2:1], blue[2:1], changed[2:1]);
        end
        step();
        checks++;
        if ({red[1], green[1], blue[1], changed[1]} !== 4'b0011) begin
            failures++;
            $display("FAIL signed_mode: rgbc=%b expected 0011", {red[1], green[1], blue[1], changed[1]});
        end
        checks++;
        if ({red[2], green[2], blue[2], changed[2]} !== 4'b1001) begin
            failures++;
            $display("FAIL unsigned_mode: rgbc=%b expected 1001", {red[2], green[2], blue[2], changed[2]});
        end
    endtask

    task automatic test_freeze_reset();
        logic [3:0] want;
        a0 = 8'd3; b0 = 8'd9; en = 1'b1;
        step(); step(); step();
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if ({red[0], green[0], blue[0], changed[0]} !== 4'b0100) begin
                failures++;
                $display("FAIL freeze cyc%0d: rgbc=%b expected 0100", k,
                         {red[0], green[0], blue[0], changed[0]});
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            step();
            want = (k == 2) ? 4'b0011 : 4'b0100;
            checks++;
            if ({red[0], green[0], blue[0], changed[0]} !== want) begin
                failures++;
                $display("FAIL freeze_resume edge%0d: rgbc=%b expected %b", k,
                         {red[0], green[0], blue[0], changed[0]}, want);
            end
        end
        a0 = 8'd9; b0 = 8'd3;
        step(); step(); step();
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({red, green, blue, changed} !== '0) begin
            failures++;
            $display("FAIL reset_mid_pending: r=%b g=%b b=%b c=%b expected all 0", red, green, blue, changed);
        end
        #1 rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            want = (k < 5) ? 4'b0000 : {3'b100, k == 5};
            checks++;
            if ({red[0], green[0], blue[0], changed[0]} !== want) begin
                failures++;
                $display("FAIL requalify edge%0d: rgbc=%b expected %b", k,
                         {red[0], green[0], blue[0], changed[0]}, want);
            end
        end
    endtask

    task automatic test_sweep();
        int prev, c;
        logic [3:0] want;
        aw = 2'd0; bw = 2'd0; en = 1'b1;
        step(); step(); step();
        prev = 2;
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                aw = 2'(ai); bw = 2'(bi);
                c  = cls_of(ai, bi);
                for (int k = 1; k <= 4; k++) begin
                    step();
                    want = (k == 1) ? onehot(prev) : (onehot(c) | {3'b000, k == 2 && c != prev});
                    checks++;
                    if ({red[3], green[3], blue[3], changed[3]} !== want) begin
                        failures++;
                        $display("FAIL sweep a=%0d b=%0d edge%0d: rgbc=%b expected %b", ai, bi, k,
                                 {red[3], green[3], blue[3], changed[3]}, want);
                    end
                end
                prev = c;
            end
        end
    endtask

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'h01;
            2:       return 8'h7F;
            3:       return 8'h80;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            en = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) < 3) begin a0 = pick8(); b0 = pick8(); end
            if ($urandom_range(0, 9) < 3) begin a_s = pick8(); b_s = pick8(); end
            if ($urandom_range(0, 9) < 3) begin aw = 2'($urandom_range(0, 3)); bw = 2'($urandom_range(0, 3)); end
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1 rst = 1'b0;
            end
            step();
            for (int i = 0; i < N; i++) begin
                checks++;
                if ({red[i], green[i], blue[i], changed[i]} !== exp_out(i)) begin
                    failures++;
                    $display("FAIL random inst%0d cyc%0d: rgbc=%b expected %b", i, k,
                             {red[i], green[i], blue[i], changed[i]}, exp_out(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_commit_latency();
        test_glitch();
        test_signed();
        test_freeze_reset();
        test_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
